// File: rtl/gpu_raster_pkg.sv
// gpu_raster_pkg
// Shared types and constants for the line rasteriser and the command decoder.
//   mode_t          : request kind latched at start (DRAW / CLEAR)
//   raster_state_t  : rasteriser FSM states
//   OP_*            : 3-bit command opcodes understood by the decoder
//   maxInt          : elaboration-time helper for width sizing
// Optional feature macro used by the rasteriser: GPU_RASTER_CLIP_EN.
package gpu_raster_pkg;

  typedef enum logic {
    MODE_DRAW  = 1'b0,
    MODE_CLEAR = 1'b1
  } mode_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_LINE,
    ST_CLEAR,
    ST_DONE
  } raster_state_t;

  localparam logic [2:0] OP_CLEAR      = 3'b000;
  localparam logic [2:0] OP_SET_START  = 3'b001;
  localparam logic [2:0] OP_SET_END    = 3'b010;
  localparam logic [2:0] OP_SET_COLOR  = 3'b011;
  localparam logic [2:0] OP_MOVE_START = 3'b100;
  localparam logic [2:0] OP_MOVE_END   = 3'b101;
  localparam logic [2:0] OP_DRAW       = 3'b110;
  localparam logic [2:0] OP_FLIP       = 3'b111;

  function automatic int maxInt(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/gpu_pix_addr.sv
// gpu_pix_addr
// Combinational framebuffer address mapping, shared with the scanout logic.
//   addr_o = BASE_ADDR + (buf_i*YMAX + y_i)*XMAX + x_i, modulo 2**ADDR_W.
// Ports:
//   x_i    [X_W]    pixel column
//   y_i    [Y_W]    pixel row inside the buffer
//   buf_i  [BUF_W]  stacked buffer index
//   addr_o [ADDR_W] flat pixel address
module gpu_pix_addr #(
  parameter int XMAX   = 320,
  parameter int YMAX   = 240,
  parameter int X_W    = 9,
  parameter int Y_W    = 8,
  parameter int BUF_W  = 1,
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic [X_W-1:0]    x_i,
  input  logic [Y_W-1:0]    y_i,
  input  logic [BUF_W-1:0]  buf_i,
  output logic [ADDR_W-1:0] addr_o
);

  logic [ADDR_W-1:0] rowIdx;

  // Buffers are stacked vertically, so the buffer index just offsets the row.
  assign rowIdx = ADDR_W'(buf_i) * ADDR_W'(YMAX) + ADDR_W'(y_i);
  assign addr_o = BASE_ADDR + rowIdx * ADDR_W'(XMAX) + ADDR_W'(x_i);

endmodule

// File: rtl/gpu_line_raster.sv
// gpu_line_raster
// Turns a latched DRAW (Bresenham line, all octants) or CLEAR (whole buffer)
// request into a stream of framebuffer pixel writes, one per valid/ready
// handshake.
// Ports:
//   clk, n_rst            clock, asynchronous active-low reset
//   start, mode           request strobe (sampled in IDLE), 0=DRAW 1=CLEAR
//   x0, y0, x1, y1        line endpoints
//   color, buf_sel        pixel colour and target buffer
//   px_valid / px_ready   pixel write handshake
//   px_addr, px_data      flat pixel address and colour
//   busy, done            request in flight, one-cycle completion pulse
//   clip_cnt              (GPU_RASTER_CLIP_EN only) skipped off-screen pixels
// Macro GPU_RASTER_CLIP_EN: when defined, LINE pixels outside the screen are
// walked but not emitted, and counted in clip_cnt.
module gpu_line_raster
  import gpu_raster_pkg::*;
#(
  parameter int XMAX   = 320,
  parameter int YMAX   = 240,
  parameter int X_W    = 9,
  parameter int Y_W    = 8,
  parameter int PIX_W  = 24,
  parameter int NBUF   = 2,
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  localparam int BUF_W = (NBUF > 1) ? $clog2(NBUF) : 1
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start,
  input  logic              mode,
  input  logic [X_W-1:0]    x0,
  input  logic [X_W-1:0]    x1,
  input  logic [Y_W-1:0]    y0,
  input  logic [Y_W-1:0]    y1,
  input  logic [PIX_W-1:0]  color,
  input  logic [BUF_W-1:0]  buf_sel,
  output logic              px_valid,
  input  logic              px_ready,
  output logic [ADDR_W-1:0] px_addr,
  output logic [PIX_W-1:0]  px_data,
  output logic              busy,
  output logic              done
`ifdef GPU_RASTER_CLIP_EN
  ,
  output logic [15:0]       clip_cnt
`endif
);

  localparam int ERR_W = maxInt(X_W, Y_W) + 2;

  raster_state_t state_q, state_d;
  mode_t             mode_q;
  logic [X_W-1:0]    x1_q;
  logic [Y_W-1:0]    y1_q;
  logic [PIX_W-1:0]  color_q;
  logic [BUF_W-1:0]  buf_q;

  logic [X_W-1:0]    xPos_q, xPos_d;
  logic [Y_W-1:0]    yPos_q, yPos_d;
  logic signed [ERR_W-1:0] dx_q, dx_d, dy_q, dy_d, err_q, err_d;
  logic              sxNeg_q, sxNeg_d, syNeg_q, syNeg_d;

  logic signed [ERR_W-1:0] dxDiff, dyDiff, dxAbs, dyAbs, dxAdd, dyAdd, errStep;
  logic signed [ERR_W:0]   e2, dxExt, dyExt;
  logic              stepX, stepY, atEnd, pixClipped, pixActive;
  logic [ADDR_W-1:0] pixAddr;

  // Request parameters are frozen at start so later input changes are ignored.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      mode_q  <= MODE_DRAW;
      x1_q    <= '0;
      y1_q    <= '0;
      color_q <= '0;
      buf_q   <= '0;
    end else if (state_q == ST_IDLE && start) begin
      mode_q  <= mode_t'(mode);
      x1_q    <= x1;
      y1_q    <= y1;
      color_q <= color;
      buf_q   <= buf_sel;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= ST_IDLE;
      xPos_q  <= '0;
      yPos_q  <= '0;
      dx_q    <= '0;
      dy_q    <= '0;
      err_q   <= '0;
      sxNeg_q <= 1'b0;
      syNeg_q <= 1'b0;
    end else begin
      state_q <= state_d;
      xPos_q  <= xPos_d;
      yPos_q  <= yPos_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      err_q   <= err_d;
      sxNeg_q <= sxNeg_d;
      syNeg_q <= syNeg_d;
    end
  end

  // In SETUP xPos/yPos still hold the start point, so deltas come from them.
  assign dxDiff = $signed(ERR_W'(x1_q)) - $signed(ERR_W'(xPos_q));
  assign dyDiff = $signed(ERR_W'(y1_q)) - $signed(ERR_W'(yPos_q));
  assign dxAbs  = dxDiff[ERR_W-1] ? -dxDiff : dxDiff;
  assign dyAbs  = dyDiff[ERR_W-1] ? -dyDiff : dyDiff;

  // e2 needs one extra bit because it is twice the error term.
  assign e2      = $signed({err_q, 1'b0});
  assign dxExt   = (ERR_W+1)'(dx_q);
  assign dyExt   = (ERR_W+1)'(dy_q);
  assign stepX   = (e2 >= dyExt);
  assign stepY   = (e2 <= dxExt);
  assign dyAdd   = stepX ? dy_q : '0;
  assign dxAdd   = stepY ? dx_q : '0;
  assign errStep = err_q + dyAdd + dxAdd;
  assign atEnd   = (xPos_q == x1_q) && (yPos_q == y1_q);

`ifdef GPU_RASTER_CLIP_EN
  logic [15:0] clipCnt_q, clipCnt_d;

  assign pixClipped = (32'(xPos_q) >= 32'(XMAX)) || (32'(yPos_q) >= 32'(YMAX));

  always_comb begin
    clipCnt_d = clipCnt_q;
    if (state_q == ST_IDLE && start) begin
      clipCnt_d = '0;
    end else if (state_q == ST_LINE && pixClipped && clipCnt_q != 16'hFFFF) begin
      clipCnt_d = clipCnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) clipCnt_q <= '0;
    else        clipCnt_q <= clipCnt_d;
  end

  assign clip_cnt = clipCnt_q;
`else
  assign pixClipped = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    xPos_d   = xPos_q;
    yPos_d   = yPos_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    err_d    = err_q;
    sxNeg_d  = sxNeg_q;
    syNeg_d  = syNeg_q;
    px_valid = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) begin
          xPos_d  = x0;
          yPos_d  = y0;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        dx_d    = dxAbs;
        dy_d    = -dyAbs;
        err_d   = dxAbs - dyAbs;
        sxNeg_d = dxDiff[ERR_W-1];
        syNeg_d = dyDiff[ERR_W-1];
        if (mode_q == MODE_CLEAR) begin
          xPos_d  = '0;
          yPos_d  = '0;
          state_d = ST_CLEAR;
        end else begin
          state_d = ST_LINE;
        end
      end
      ST_LINE: begin
        // Clipped pixels advance without a handshake.
        px_valid = !pixClipped;
        if (pixClipped || px_ready) begin
          if (atEnd) begin
            state_d = ST_DONE;
          end else begin
            err_d = errStep;
            if (stepX) xPos_d = sxNeg_q ? xPos_q - X_W'(1) : xPos_q + X_W'(1);
            if (stepY) yPos_d = syNeg_q ? yPos_q - Y_W'(1) : yPos_q + Y_W'(1);
          end
        end
      end
      ST_CLEAR: begin
        px_valid = 1'b1;
        if (px_ready) begin
          if (32'(xPos_q) == 32'(XMAX - 1)) begin
            xPos_d = '0;
            if (32'(yPos_q) == 32'(YMAX - 1)) state_d = ST_DONE;
            else                              yPos_d  = yPos_q + Y_W'(1);
          end else begin
            xPos_d = xPos_q + X_W'(1);
          end
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        busy    = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  gpu_pix_addr #(
    .XMAX      (XMAX),
    .YMAX      (YMAX),
    .X_W       (X_W),
    .Y_W       (Y_W),
    .BUF_W     (BUF_W),
    .ADDR_W    (ADDR_W),
    .BASE_ADDR (BASE_ADDR)
  ) uPixAddr (
    .x_i    (xPos_q),
    .y_i    (yPos_q),
    .buf_i  (buf_q),
    .addr_o (pixAddr)
  );

  // Address/data are forced to zero outside pixel states so the reset and
  // idle values are zero whatever BASE_ADDR is.
  assign pixActive = (state_q == ST_LINE) || (state_q == ST_CLEAR);
  assign px_addr   = pixActive ? pixAddr : '0;
  assign px_data   = pixActive ? color_q : '0;

endmodule

// File: tb/tb_gpu_line_raster.sv
// tb_gpu_line_raster
// Self-checking bench for gpu_line_raster. Two instances share the stimulus:
// a default-geometry one for line drawing and a 4x2 one for CLEAR, whose
// full-buffer fill is then short. Expected pixel streams come from a
// behavioural model (plain integer Bresenham / raster loops and the flat
// address formula). Honours GPU_RASTER_CLIP_EN when defined.
module tb_gpu_line_raster;

  logic        clk;
  logic        n_rst;
  logic        start;
  logic        startS;
  logic        mode;
  logic [8:0]  x0, x1;
  logic [7:0]  y0, y1;
  logic [23:0] color;
  logic        buf_sel;
  logic        px_ready;

  logic        mValid, mBusy, mDone;
  logic [31:0] mAddr;
  logic [23:0] mData;
  logic        sValid, sBusy, sDone;
  logic [31:0] sAddr;
  logic [23:0] sData;
`ifdef GPU_RASTER_CLIP_EN
  logic [15:0] mClip, sClip;
`endif

  logic        useSmall;
  logic        obsValid, obsBusy, obsDone;
  logic [31:0] obsAddr;
  logic [23:0] obsData;

  int checkCount;
  int errorCount;

  int unsigned expQ[$];
  int          expClip;

  gpu_line_raster dut (
    .clk      (clk),
    .n_rst    (n_rst),
    .start    (start),
    .mode     (mode),
    .x0       (x0),
    .x1       (x1),
    .y0       (y0),
    .y1       (y1),
    .color    (color),
    .buf_sel  (buf_sel),
    .px_valid (mValid),
    .px_ready (px_ready),
    .px_addr  (mAddr),
    .px_data  (mData),
    .busy     (mBusy),
    .done     (mDone)
`ifdef GPU_RASTER_CLIP_EN
    ,
    .clip_cnt (mClip)
`endif
  );

  gpu_line_raster #(.XMAX(4), .YMAX(2)) dutSmall (
    .clk      (clk),
    .n_rst    (n_rst),
    .start    (startS),
    .mode     (mode),
    .x0       (x0),
    .x1       (x1),
    .y0       (y0),
    .y1       (y1),
    .color    (color),
    .buf_sel  (buf_sel),
    .px_valid (sValid),
    .px_ready (px_ready),
    .px_addr  (sAddr),
    .px_data  (sData),
    .busy     (sBusy),
    .done     (sDone)
`ifdef GPU_RASTER_CLIP_EN
    ,
    .clip_cnt (sClip)
`endif
  );

  assign obsValid = useSmall ? sValid : mValid;
  assign obsBusy  = useSmall ? sBusy  : mBusy;
  assign obsDone  = useSmall ? sDone  : mDone;
  assign obsAddr  = useSmall ? sAddr  : mAddr;
  assign obsData  = useSmall ? sData  : mData;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic int unsigned pixAddrModel(input int bsel, input int xmax,
                                               input int ymax, input int x, input int y);
    return int'((bsel * ymax + y) * xmax + x);
  endfunction

  // Reference line walk straight from the Bresenham rules, in plain ints.
  task automatic buildLine(input int ax0, input int ay0, input int ax1, input int ay1,
                           input int bsel, input int xmax, input int ymax);
    int dx, dy, sx, sy, err, e2, x, y;
    expQ.delete();
    expClip = 0;
    dx  = (ax1 > ax0) ? ax1 - ax0 : ax0 - ax1;
    dy  = -((ay1 > ay0) ? ay1 - ay0 : ay0 - ay1);
    sx  = (ax0 < ax1) ? 1 : -1;
    sy  = (ay0 < ay1) ? 1 : -1;
    err = dx + dy;
    x   = ax0;
    y   = ay0;
    for (int n = 0; n < 2000; n++) begin
`ifdef GPU_RASTER_CLIP_EN
      if (x >= xmax || y >= ymax) expClip++;
      else
`endif
      expQ.push_back(pixAddrModel(bsel, xmax, ymax, x, y));
      if (x == ax1 && y == ay1) break;
      e2 = 2 * err;
      if (e2 >= dy) begin err += dy; x += sx; end
      if (e2 <= dx) begin err += dx; y += sy; end
    end
  endtask

  task automatic buildClear(input int bsel, input int xmax, input int ymax);
    expQ.delete();
    expClip = 0;
    for (int y = 0; y < ymax; y++)
      for (int x = 0; x < xmax; x++)
        expQ.push_back(pixAddrModel(bsel, xmax, ymax, x, y));
  endtask

  // Issues one request and follows it to completion, checking every pixel
  // presented, the handshake hold behaviour, and the done pulse timing.
  task automatic applyStimulus(input bit isSmall, input bit md,
                               input int ax0, input int ay0, input int ax1, input int ay1,
                               input int bsel, input logic [23:0] col,
                               input int readyProb, input int stallPixel, input bit midStart);
    int xm, ym, expTotal, accepted, stallLeft, budget;
    bit doneSeen, stalled, lastAccepted, first;
    logic [31:0] holdAddr;
    logic [23:0] holdData;
    int unsigned want;
    xm = isSmall ? 4 : 320;
    ym = isSmall ? 2 : 240;
    if (md) buildClear(bsel, xm, ym);
    else    buildLine(ax0, ay0, ax1, ay1, bsel, xm, ym);
    expTotal  = expQ.size();
    budget    = expTotal * 20 + expClip + 64;
    accepted  = 0;
    stallLeft = 3;
    doneSeen  = 1'b0;
    stalled   = 1'b0;
    lastAccepted = 1'b0;
    first     = 1'b1;
    holdAddr  = '0;
    holdData  = '0;

    @(negedge clk);
    useSmall = isSmall;
    mode     = md;
    x0       = 9'(ax0);
    y0       = 8'(ay0);
    x1       = 9'(ax1);
    y1       = 8'(ay1);
    buf_sel  = 1'(bsel);
    color    = col;
    px_ready = 1'b0;
    if (isSmall) startS = 1'b1;
    else         start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    startS = 1'b0;
    #1;
    checkOutput("setupValid", obsValid, 1'b0);
    checkOutput("setupBusy", obsBusy, 1'b1);

    for (int cyc = 0; cyc < budget && !doneSeen; cyc++) begin
      @(negedge clk);
      if (stallPixel >= 0 && accepted == stallPixel && stallLeft > 0) begin
        px_ready = 1'b0;
        stallLeft--;
      end else begin
        px_ready = ($urandom_range(99) < readyProb);
      end
      if (midStart && cyc == 3) begin
        if (isSmall) startS = 1'b1;
        else         start  = 1'b1;
        buf_sel = ~buf_sel;
        color   = ~color;
      end
      if (midStart && cyc == 4) begin
        start  = 1'b0;
        startS = 1'b0;
      end
      #1;
      if (first) checkOutput("firstValid", obsValid, (md || expClip == 0) ? 1'b1 : obsValid);
      first = 1'b0;
      if (obsDone) begin
        doneSeen = 1'b1;
        checkOutput("doneNoValid", obsValid, 1'b0);
        checkOutput("pixelCount", accepted, expTotal);
`ifndef GPU_RASTER_CLIP_EN
        checkOutput("doneAfterLast", lastAccepted, 1'b1);
`else
        if (!md) checkOutput("clipCnt", isSmall ? sClip : mClip, expClip);
`endif
      end else if (obsValid) begin
        if (stalled) begin
          checkOutput("holdAddr", obsAddr, holdAddr);
          checkOutput("holdData", obsData, holdData);
        end
        if (px_ready) begin
          if (expQ.size() == 0) begin
            checkOutput("extraPixel", obsAddr, 32'hFFFF_FFFF);
          end else begin
            want = expQ.pop_front();
            checkOutput("pixAddr", obsAddr, want);
            checkOutput("pixData", obsData, col);
          end
          accepted++;
          lastAccepted = (expQ.size() == 0);
          stalled = 1'b0;
        end else begin
          stalled  = 1'b1;
          holdAddr = obsAddr;
          holdData = obsData;
          lastAccepted = 1'b0;
        end
      end else begin
        lastAccepted = 1'b0;
        stalled = 1'b0;
      end
    end
    checkOutput("doneReached", doneSeen, 1'b1);
    if (doneSeen) begin
      @(negedge clk);
      #1;
      checkOutput("donePulseLen", obsDone, 1'b0);
      checkOutput("idleBusy", obsBusy, 1'b0);
    end
    px_ready = 1'b0;
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    n_rst    = 1'b0;
    start    = 1'b0;
    startS   = 1'b0;
    mode     = 1'b0;
    x0 = '0; x1 = '0; y0 = '0; y1 = '0;
    color    = '0;
    buf_sel  = 1'b0;
    px_ready = 1'b0;
    useSmall = 1'b0;

    repeat (3) @(negedge clk);
    #1;
    checkOutput("rstValid", mValid, 1'b0);
    checkOutput("rstAddr", mAddr, 32'd0);
    checkOutput("rstData", mData, 24'd0);
    checkOutput("rstBusy", mBusy, 1'b0);
    checkOutput("rstDone", mDone, 1'b0);
    @(negedge clk);
    n_rst = 1'b1;

    $display("[TB] horizontal line (0,0)->(3,0)");
    applyStimulus(1'b0, 1'b0, 0, 0, 3, 0, 0, 24'h123456, 100, -1, 1'b0);
    $display("[TB] steep reverse line (2,5)->(0,0) in buffer 1");
    applyStimulus(1'b0, 1'b0, 2, 5, 0, 0, 1, 24'hABCDEF, 100, -1, 1'b0);
    $display("[TB] degenerate line at (7,7)");
    applyStimulus(1'b0, 1'b0, 7, 7, 7, 7, 0, 24'h00FF00, 100, -1, 1'b0);
    $display("[TB] back-pressure on second pixel");
    applyStimulus(1'b0, 1'b0, 0, 0, 3, 0, 0, 24'h0F0F0F, 100, 1, 1'b0);
    $display("[TB] CLEAR of small buffer 1 with stray start");
    applyStimulus(1'b1, 1'b1, 0, 0, 0, 0, 1, 24'hFF0000, 100, -1, 1'b1);
    applyStimulus(1'b1, 1'b1, 0, 0, 0, 0, 0, 24'h00000F, 60, -1, 1'b0);

    $display("[TB] reset during a long line");
    @(negedge clk);
    useSmall = 1'b0;
    mode = 1'b0;
    x0 = 9'd0; y0 = 8'd0; x1 = 9'd300; y1 = 8'd200;
    px_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    n_rst = 1'b0;
    #1;
    checkOutput("midRstValid", mValid, 1'b0);
    checkOutput("midRstBusy", mBusy, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      checkOutput("midRstDone", mDone, 1'b0);
    end
    n_rst = 1'b1;
    @(negedge clk);
    #1;
    checkOutput("postRstValid", mValid, 1'b0);
    checkOutput("postRstDone", mDone, 1'b0);
    px_ready = 1'b0;
    applyStimulus(1'b0, 1'b0, 0, 0, 3, 0, 0, 24'h5A5A5A, 100, -1, 1'b0);

`ifdef GPU_RASTER_CLIP_EN
    $display("[TB] line running off the right edge");
    applyStimulus(1'b0, 1'b0, 318, 0, 321, 0, 0, 24'h777777, 100, -1, 1'b0);
`endif

    $display("[TB] randomized lines");
    for (int n = 0; n < 12; n++) begin
      applyStimulus(1'b0, 1'b0,
                    int'($urandom_range(319)), int'($urandom_range(239)),
                    int'($urandom_range(319)), int'($urandom_range(239)),
                    int'($urandom_range(1)), 24'($urandom),
                    int'($urandom_range(100, 50)), -1, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/gpu_line_raster.md
Name: gpu_line_raster

Overview:
- Parametrised rasteriser between the GPU command decoder (APB side) and the AHB pixel-write master.
- Takes a latched DRAW or CLEAR request and emits one framebuffer pixel write per accepted handshake.
- Supports any screen geometry, colour width and number of stacked frame buffers.
- DRAW walks a Bresenham line in all octants. CLEAR fills a whole buffer.

Parameters:
- XMAX, 320, screen width in pixels
- YMAX, 240, screen height in pixels per buffer
- X_W, 9, x coordinate width
- Y_W, 8, y coordinate width
- PIX_W, 24, colour width
- NBUF, 2, number of stacked buffers
- ADDR_W, 32, pixel address width
- BASE_ADDR, 0, address of pixel (0,0) of buffer 0

Ports:
- clk  in  1  system clock
- n_rst  in  1  asynchronous active-low reset
- start  in  1  one-cycle request strobe
- mode  in  1  0=DRAW, 1=CLEAR
- x0, x1  in  X_W  start and end x
- y0, y1  in  Y_W  start and end y
- color  in  PIX_W  pixel colour
- buf_sel  in  $clog2(NBUF)  target buffer
- px_valid  out  1  pixel write pending
- px_ready  in  1  AHB master accepts pixel
- px_addr  out  ADDR_W  flat pixel address
- px_data  out  PIX_W  pixel colour
- busy  out  1  request in progress
- done  out  1  one-cycle completion pulse

Behaviour:
- Single clock, asynchronous active-low reset n_rst, active on posedge clk.
- Reset values: px_valid=0, px_addr=0, px_data=0, busy=0, done=0, FSM=IDLE. Reset mid-operation abandons the request with no further pixels and no done pulse.
- Address rule: px_addr = BASE_ADDR + (buf_sel*YMAX + y)*XMAX + x, computed to ADDR_W bits, unsigned, no saturation. Buffer b occupies rows b*YMAX .. b*YMAX+YMAX-1.
- Inputs are latched when start=1 in IDLE. start in any other state is ignored. color and buf_sel are held constant for the whole request.
- FSM states: IDLE, SETUP, LINE, CLEAR, DONE.
  - IDLE -> SETUP on start.
  - SETUP: one cycle. Computes the DRAW terms dx=|x1-x0|, dy=-|y1-y0|, sx/sy=+1 or -1, err=dx+dy; err is signed, max(X_W,Y_W)+2 bits. For CLEAR it sets x=0, y=0. Then goes to LINE or CLEAR according to mode.
  - LINE/CLEAR: px_valid=1 with the current pixel.
    - On px_valid&&px_ready the next pixel is presented in the following cycle. px_valid stays high between consecutive pixels; there are no bubbles.
    - While px_ready=0, px_addr and px_data hold stable.
  - LINE step: e2=2*err. If e2>=dy: err+=dy, x+=sx. If e2<=dx: err+=dx, y+=sy. Both updates can occur in the same step.
  - LINE termination: the pixel at (x1,y1) is the last one. Its acceptance moves the FSM to DONE. Emits max(dx,-dy)+1 pixels, endpoints inclusive.
  - CLEAR order: raster order, x increments first and wraps XMAX-1 -> 0 with y+1. Acceptance of (XMAX-1,YMAX-1) moves to DONE. Emits exactly XMAX*YMAX pixels.
  - DONE: done=1 for one cycle, px_valid=0, then IDLE.
- Latency: first px_valid is asserted 2 cycles after the start edge.
- busy=1 in SETUP, LINE, CLEAR and DONE.
- Degenerate line (x0==x1 and y0==y1): exactly one pixel.

Optional Feature:
- Macro: GPU_RASTER_CLIP_EN.
- Defined: LINE pixels with x>=XMAX or y>=YMAX are skipped internally; the walk continues at one pixel per cycle with px_valid=0 for those pixels. An output clip_cnt (16 bits) counts skipped pixels; it clears on start and saturates at 16'hFFFF.
- Undefined: every walked pixel is emitted with its raw address, and the clip_cnt port is absent.
- CLEAR is unaffected in both builds.

Decomposition:
- Package gpu_raster_pkg holds:
  - the mode_t enum (DRAW, CLEAR) and the raster_state_t enum;
  - the command opcode constants shared with the decoder: CLEAR=000, SET_START=001, SET_END=010, SET_COLOR=011, MOVE_START=100, MOVE_END=101, DRAW=110, FLIP=111.
- Sub-module gpu_pix_addr: combinational (x, y, buf_sel) -> px_addr mapping, reused by the flip/scanout logic.

Test Plan:
- DRAW (0,0)->(3,0), buf 0, px_ready=1 -> addresses 0,1,2,3 on consecutive cycles; first valid 2 cycles after start; done 1 cycle after address 3 is accepted.
- DRAW (2,5)->(0,0), buf 1, defaults -> 6 pixels, first address 76800+5*320+2=78402, last 76800, y strictly decreasing each step.
- DRAW (7,7)->(7,7) -> exactly one pixel at address 2247, then done.
- px_ready low for 3 cycles on the 2nd pixel of (0,0)->(3,0) -> px_addr=1 and px_data stable throughout; no pixel dropped or duplicated.
- CLEAR with XMAX=4, YMAX=2, buf 1, color 24'hFF0000 -> 8 pixels, addresses 8..15, data FF0000; a start pulsed mid-clear is ignored.
- n_rst asserted mid-DRAW -> px_valid=0 immediately; no done pulse; a new start after release runs normally. With GPU_RASTER_CLIP_EN, DRAW (318,0)->(321,0) -> 2 pixels emitted, clip_cnt=2.
